// File: rtl/serial_twos_comp_pkg.sv
// Shared types for the word-framed serial two's-complement unit.
package serial_twos_comp_pkg;

  typedef enum logic [1:0] {
    PASS = 2'b00,
    NEG  = 2'b01,
    ABS  = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_COPY,
    S_INV
  } emit_state_t;

  // The unused encoding 2'b11 behaves as PASS.
  function automatic mode_t decode_mode(logic [1:0] raw);
    case (raw)
      2'b01:   return NEG;
      2'b10:   return ABS;
      default: return PASS;
    endcase
  endfunction

endpackage

// File: rtl/serial_twos_comp_word_if.sv
// Serial in/out bundle between the link receiver, this unit and downstream arithmetic.
interface serial_twos_comp_word_if;

  logic       in_valid;
  logic       in_bit;
  logic       in_first;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_bit;
  logic       out_first;
  logic       out_last;
  logic       ovf;
  logic       err_frame;

  modport master (
    output in_valid, in_bit, in_first, mode,
    input  out_valid, out_bit, out_first, out_last, ovf, err_frame
  );

  modport slave (
    input  in_valid, in_bit, in_first, mode,
    output out_valid, out_bit, out_first, out_last, ovf, err_frame
  );

endinterface

// File: rtl/serial_negator.sv
// Per-bit emit FSM: copies bits up to and including the first 1, then inverts the rest.
module serial_negator
  import serial_twos_comp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        load_i,
  input  logic        neg_i,
  input  logic        bit_i,
  input  logic        last_i,
  output logic        res_o,
  output emit_state_t state_o
);

  emit_state_t state_q;
  logic        res_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      res_q   <= 1'b0;
    end else begin
      case (state_q)
        S_INV:   res_q <= ~bit_i;
        S_IDLE:  res_q <= 1'b0;
        default: res_q <= bit_i;
      endcase
      // A new word may load on the same edge the previous word's last bit leaves.
      if (load_i) begin
        state_q <= neg_i ? S_COPY : S_PASS;
      end else if (state_q != S_IDLE && last_i) begin
        state_q <= S_IDLE;
      end else if (state_q == S_COPY && bit_i) begin
        state_q <= S_INV;
      end
    end
  end

  assign res_o   = res_q;
  assign state_o = state_q;

endmodule

// File: rtl/serial_twos_comp_word.sv
// Captures WIDTH-bit LSB-first words and re-emits them as pass, negated or absolute value.
module serial_twos_comp_word
  import serial_twos_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_b,
  serial_twos_comp_word_if.slave bus_io
);

  localparam int unsigned      CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  mode_t            mode_q, mode_d;
  logic             err_d;
  logic             xfer;
  logic             neg_flag;
  logic             is_min;

  logic [WIDTH-1:0] emit_q;
  logic             emit_ovf_q;
  logic [CntW-1:0]  idx_q;

  logic             out_valid_q;
  logic             out_first_q;
  logic             out_last_q;
  logic             ovf_q;
  logic             err_q;

  emit_state_t      emit_state;
  logic             res_bit;
  logic             active;
  logic             last_bit;

  always_comb begin
    cnt_d  = cnt_q;
    cap_d  = cap_q;
    mode_d = mode_q;
    err_d  = 1'b0;
    xfer   = 1'b0;
    if (bus_io.in_valid) begin
      if (bus_io.in_first) begin
        err_d    = (cnt_q != '0);
        cnt_d    = CntW'(1);
        cap_d[0] = bus_io.in_bit;
        mode_d   = decode_mode(bus_io.mode);
      end else if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        cap_d[cnt_q] = bus_io.in_bit;
        if (cnt_q == LastIdx) begin
          xfer  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end
  end

  // The incoming bit is the MSB on the completing edge.
  assign neg_flag = (mode_q == NEG) || ((mode_q == ABS) && bus_io.in_bit);
  assign is_min   = bus_io.in_bit && (cap_q[WIDTH-2:0] == '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q  <= '0;
      cap_q  <= '0;
      mode_q <= PASS;
    end else begin
      cnt_q  <= cnt_d;
      cap_q  <= cap_d;
      mode_q <= mode_d;
    end
  end

  assign active   = (emit_state != S_IDLE);
  assign last_bit = (idx_q == LastIdx);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      emit_q     <= '0;
      emit_ovf_q <= 1'b0;
      idx_q      <= '0;
    end else if (xfer) begin
      emit_q     <= cap_d;
      emit_ovf_q <= neg_flag && is_min;
      idx_q      <= '0;
    end else if (active) begin
      idx_q <= idx_q + CntW'(1);
    end
  end

  serial_negator u_negator (
    .clk     (clk),
    .rst_b   (rst_b),
    .load_i  (xfer),
    .neg_i   (neg_flag),
    .bit_i   (emit_q[idx_q]),
    .last_i  (last_bit),
    .res_o   (res_bit),
    .state_o (emit_state)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= active;
      out_first_q <= active && (idx_q == '0);
      out_last_q  <= active && last_bit;
      ovf_q       <= active && last_bit && emit_ovf_q;
      err_q       <= err_d;
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_bit   = res_bit;
  assign bus_io.out_first = out_first_q;
  assign bus_io.out_last  = out_last_q;
  assign bus_io.ovf       = ovf_q;
  assign bus_io.err_frame = err_q;

endmodule

// File: doc/serial_twos_comp_word.md
# serial_twos_comp_word

Word-framed, LSB-first bit-serial two's-complement unit. It is the parametrised successor of the team's single-stream serial complementer. Each WIDTH-bit serial word is captured, then re-emitted bit-serially as pass-through, negated, or absolute value, selected per word. It sits between a serial link receiver and downstream serial arithmetic. It sustains one bit per cycle with double buffering and flags most-negative overflow.

## Interface
- WIDTH, 8, word length in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst_b  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_bit/in_first/mode valid this cycle
- in_bit  in  1  serial data, LSB first
- in_first  in  1  marks bit 0 of a word (qualified by in_valid)
- mode  in  2  00 PASS, 01 NEG, 10 ABS, 11 treated as PASS; sampled with the first bit
- out_valid  out  1  out_bit valid
- out_bit  out  1  serial result, LSB first
- out_first  out  1  result bit 0
- out_last  out  1  result bit WIDTH-1
- ovf  out  1  with out_last: NEG/ABS applied to the most-negative value (1 followed by WIDTH-1 zeros)
- err_frame  out  1  one-cycle framing-error pulse

## Operation
- Capture side: bit counter 0..WIDTH-1 and a WIDTH-bit capture shift register.
  - in_valid & in_first: counter := 1, bit stored at position 0, mode latched.
  - in_valid & !in_first with counter ≠ 0: store the bit and increment the counter.
  - in_valid low: counter and capture register hold, so gaps are allowed.
- Word complete: on the edge that samples bit WIDTH-1, the word, its mode and its negate flag transfer to the emit buffer, and the counter returns to 0.
  - Negate flag = NEG, or ABS with captured MSB = 1.
- Framing errors:
  - in_first with counter ≠ 0: partial word discarded, new word starts, err_frame pulses.
  - in_valid & !in_first with counter = 0: bit ignored, err_frame pulses.
- Emit side: emits WIDTH bits on consecutive cycles, with no gaps and no backpressure. Per-bit emit FSM:
  - S_IDLE: nothing to emit. On transfer, go to S_PASS if the negate flag is 0, else S_COPY.
  - S_PASS: out_bit = stored bit.
  - S_COPY: out_bit = stored bit. A stored 1 moves the FSM to S_INV after that bit.
  - S_INV: out_bit = inverted stored bit.
  - After bit WIDTH-1 the FSM returns to S_IDLE, or loads the next pending word directly.
- ovf = negate flag & word equals the most-negative value. The output word is then the same most-negative value (wrap), with ovf asserted alongside out_last.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - NEG of 0 = 0 with no ovf.
  - ABS of a non-negative word = the word unchanged.
- Throughput: a word cannot complete faster than WIDTH cycles, so the emit buffer is always free at transfer. No overrun is possible.
- Reset mid-operation: all state is cleared, including partial capture, pending word and emission in progress. No output until a new in_first.

## Timing
- Reset values: out_valid, out_bit, out_first, out_last, ovf, err_frame = 0. Counter = 0, FSM = S_IDLE.
- All outputs are registered.
- Latency: if bit WIDTH-1 is sampled at edge n, result bit i appears at edge n+1+i.
  - out_first is high at edge n+1 only; out_last is high at edge n+WIDTH only.
  - out_valid is high for exactly WIDTH consecutive cycles per word.
- Back-to-back words at full rate give continuous out_valid. The next word's out_first directly follows the previous out_last.
- err_frame is registered one edge after the offending input.

## Structure
- Package serial_twos_comp_pkg:
  - mode_t enum: PASS, NEG, ABS.
  - emit_state_t enum: S_IDLE, S_PASS, S_COPY, S_INV.
- Sub-module serial_negator: the per-bit emit FSM. Inputs are load, negate flag and stored bit; outputs are the result bit and the current state.
- The top level holds the capture counter, the capture and emit registers, framing checks and ovf detection.

## Test plan
All scenarios use WIDTH=8.
- NEG 8'h06 (in bits 0,1,1,0,0,0,0,0) -> out 8'hFA (bits 0,1,0,1,1,1,1,1). out_first at edge n+1, ovf = 0.
- ABS 8'hF3 -> 8'h0D; ABS 8'h25 -> 8'h25; PASS 8'hF3 -> 8'hF3; mode 11 with 8'h5A -> 8'h5A.
- NEG 8'h80 -> 8'h80 with ovf = 1 on out_last; ABS 8'h80 -> 8'h80 with ovf = 1; NEG 8'h00 -> 8'h00 with ovf = 0.
- Continuous NEG words 8'h01, 8'hFF, 8'h7F -> 8'hFF, 8'h01, 8'h81. out_valid stays high for 24 cycles with no gap.
- Framing errors:
  - in_first after 3 bits of a word -> err_frame pulse, partial word dropped; the following full word 8'h02 NEG -> 8'hFE.
  - Stray in_valid with no in_first at idle -> err_frame pulse, no output.
- rst_b low during emission of bit 4 -> all outputs 0 immediately (asynchronous). After release, no output until a new framed word; that word is processed correctly.
